uart_tx_burst: RTL and testbench
================================

UART_TX_BURST -- requirements
Module: uart_tx_burst

Interface
REQ-001 Parameters SHALL be: C_CLKFREQ, 100_000_000, clock frequency in Hz; C_BAUDRATE, 115_200, line rate in baud; C_STOPBIT, 2, stop bits per frame (1 or 2); C_DATA_BITS, 8, data bits per frame (5..9); C_DEPTH, 1024, buffer words; C_LEN_WIDTH, 11, width of length/fill fields (must hold C_DEPTH).
REQ-002 aclk  in  1  single clock; all logic rising-edge.
REQ-003 areset  in  1  reset, synchronous, active-high.
REQ-004 wr_valid_i  in  1  buffer write request.
REQ-005 wr_ready_o  out  1  buffer write accepted when high with wr_valid_i.
REQ-006 wr_data_i  in  C_DATA_BITS  word stored at index fill_o.
REQ-007 wr_clr_i  in  1  clears fill_o to 0 (contents kept).
REQ-008 data_length_i  in  C_LEN_WIDTH  words to send, sampled at trigger.
REQ-009 sent_trig_i  in  1  burst start request.
REQ-010 parity_odd_i  in  1  1 = odd, 0 = even parity (present only with UART_TX_PARITY_EN).
REQ-011 tx_o  out  1  serial line, idle high.
REQ-012 busy_o  out  1  burst in progress.
REQ-013 done_o  out  1  one-cycle burst-complete pulse.
REQ-014 fill_o  out  C_LEN_WIDTH  words currently stored.

Function
REQ-015 Bit period SHALL be C_CLKFREQ/C_BAUDRATE cycles (integer division, truncated).
REQ-016 Write accepted when wr_valid_i and wr_ready_o; word stored at index fill_o, fill_o increments next cycle.
REQ-017 wr_ready_o SHALL be high only when busy_o=0 and fill_o<C_DEPTH.
REQ-018 wr_clr_i SHALL take priority over a same-cycle write; fill_o=0 next cycle, write dropped.
REQ-019 States: IDLE, LOAD, START, DATA, PARITY, STOP, DONE.
REQ-020 IDLE->LOAD when sent_trig_i=1 and sampled length>=1; length latched as min(data_length_i, C_DEPTH); word index=0.
REQ-021 sent_trig_i with length 0 SHALL be ignored (no busy, no done_o).
REQ-022 sent_trig_i while busy_o=1 SHALL be ignored.
REQ-023 A write accepted in the trigger cycle SHALL be committed before the burst reads it.
REQ-024 LOAD: one cycle, synchronous buffer read, tx_o high; then START.
REQ-025 START: tx_o=0 for one bit period; DATA: C_DATA_BITS bits LSB first, one bit period each.
REQ-026 PARITY state entered only with UART_TX_PARITY_EN; otherwise DATA->STOP directly.
REQ-027 STOP: tx_o=1 for C_STOPBIT bit periods; then LOAD if words remain, else DONE.
REQ-028 DONE: one cycle, done_o=1, busy_o=0; then IDLE.
REQ-029 busy_o=1 in LOAD..STOP; first start bit begins 2 cycles after trigger cycle.
REQ-030 Buffer contents and fill_o SHALL be unchanged by a burst; same burst replayable by re-trigger.

Reset
REQ-031 On areset: state IDLE, tx_o=1, busy_o=0, done_o=0, fill_o=0, wr_ready_o=1 the following cycle; counters 0.
REQ-032 Reset mid-frame SHALL abort immediately: tx_o high next cycle, no done_o; buffer storage not cleared.

Configuration
REQ-033 Macro UART_TX_PARITY_EN defined: parity_odd_i port exists; PARITY bit sent after DATA for one bit period, value XOR(data) for even, ~XOR(data) for odd; parity_odd_i sampled at trigger.
REQ-034 Macro undefined: no parity_odd_i port, no PARITY state, frame = 1+C_DATA_BITS+C_STOPBIT bits.

Verification (C_CLKFREQ=100_000_000, C_BAUDRATE=10_000_000 -> 10 cycles/bit, defaults otherwise, no parity)
REQ-035 Write 0x55, 0xA3, length 2, trigger at T -> frame 1 on tx_o T+2..T+111, LOAD T+112, frame 2 T+113..T+222 LSB first with 2 stop bits, done_o at T+223 only.
REQ-036 Parity build, write 0x07 -> odd: parity bit 0; even: parity bit 1; frame 120 cycles.
REQ-037 Length 0 trigger -> tx_o stays 1, busy_o 0, no done_o; length 2000 with fill 1024 -> exactly 1024 frames then done_o.
REQ-038 Trigger and wr_valid_i during burst -> trigger ignored, wr_ready_o=0, fill_o unchanged, single done_o.
REQ-039 1024 writes -> fill_o=1024, wr_ready_o=0; wr_clr_i -> fill_o=0, wr_ready_o=1.
REQ-040 areset in DATA of frame 1 -> tx_o=1, busy_o=0, fill_o=0 next cycle, no done_o; re-trigger with length 0 ignored.

Source files
------------

// File: rtl/uart_tx_burst.sv
// uart_tx_burst: word buffer plus UART transmitter that replays the first
// N stored words as back-to-back frames on a single trigger.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd_i port and a
// parity bit after the data bits.
module uart_tx_burst #(
  parameter int C_CLKFREQ   = 100_000_000,
  parameter int C_BAUDRATE  = 115_200,
  parameter int C_STOPBIT   = 2,
  parameter int C_DATA_BITS = 8,
  parameter int C_DEPTH     = 1024,
  parameter int C_LEN_WIDTH = 11
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [C_DATA_BITS-1:0] wr_data_i,
  input  logic                   wr_clr_i,
  input  logic [C_LEN_WIDTH-1:0] data_length_i,
  input  logic                   sent_trig_i,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_odd_i,
`endif
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [C_LEN_WIDTH-1:0] fill_o
);

  localparam int BIT_CYC = C_CLKFREQ / C_BAUDRATE;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int AW      = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

  localparam logic [C_LEN_WIDTH-1:0] DEPTH_L   = C_LEN_WIDTH'(C_DEPTH);
  localparam logic [CW-1:0]          BAUD_LAST = CW'(BIT_CYC - 1);
  localparam logic [3:0]             DATA_LAST = 4'(C_DATA_BITS - 1);
  localparam logic [3:0]             STOP_LAST = 4'(C_STOPBIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]             state;
  logic [CW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [C_LEN_WIDTH-1:0] idx;
  logic [C_LEN_WIDTH-1:0] len;
  logic [C_LEN_WIDTH-1:0] fill;
  logic [C_DATA_BITS-1:0] shreg;
  logic [C_DATA_BITS-1:0] mem [C_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic                   odd_q;
  logic                   par_q;
`endif

  logic                   bit_end;
  logic                   wr_fire;
  logic [C_LEN_WIDTH-1:0] len_clamped;

  assign bit_end     = (baud_cnt == BAUD_LAST);
  assign busy_o      = (state != S_IDLE) && (state != S_DONE);
  assign done_o      = (state == S_DONE);
  assign wr_ready_o  = !busy_o && (fill < DEPTH_L);
  assign wr_fire     = wr_valid_i && wr_ready_o && !wr_clr_i;
  assign fill_o      = fill;
  assign len_clamped = (data_length_i > DEPTH_L) ? DEPTH_L : data_length_i;

  // Buffer storage: written at the current fill index, never reset.
  always_ff @(posedge aclk) begin
    if (wr_fire) mem[fill[AW-1:0]] <= wr_data_i;
  end

  // Fill counter: clear wins over a same-cycle write.
  always_ff @(posedge aclk) begin
    if (areset || wr_clr_i) fill <= '0;
    else if (wr_fire)       fill <= fill + C_LEN_WIDTH'(1);
  end

  // Burst sequencer: frame timing, bit counting and word stepping.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      len      <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      odd_q    <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sent_trig_i && (data_length_i != '0)) begin
            len   <= len_clamped;
            idx   <= '0;
            state <= S_LOAD;
`ifdef UART_TX_PARITY_EN
            odd_q <= parity_odd_i;
`endif
          end
        end
        S_LOAD: begin
          shreg    <= mem[idx[AW-1:0]];
          idx      <= idx + C_LEN_WIDTH'(1);
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= S_START;
        end
        S_START: begin
`ifdef UART_TX_PARITY_EN
          // shreg is still the unshifted word here, so parity is taken now.
          par_q <= (^shreg) ^ odd_q;
`endif
          baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
          if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
          if (bit_end) state <= S_STOP;
        end
`endif
        S_STOP: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= (idx == len) ? S_DONE : S_LOAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Serial line driver: low for start, data LSB first, high otherwise.
  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_o = par_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// Scoreboard bench for uart_tx_burst: stimulus pushes expected words, a
// line monitor decodes frames on tx_o and compares them against the queue.
// A second, small instance checks length clamping to the buffer depth.
module tb_uart_tx_burst;

`ifdef UART_TX_PARITY_EN
  localparam int FR  = 120;
  localparam int SFR = 44;
`else
  localparam int FR  = 110;
  localparam int SFR = 40;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_valid = 1'b0, wr_clr = 1'b0, trig = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [10:0] len = '0;
  logic        wr_ready, tx, busy, done;
  logic [10:0] fill;
  logic        parity_odd = 1'b0;

  logic        s_wr_valid = 1'b0, s_trig = 1'b0;
  logic [7:0]  s_wr_data = '0;
  logic [4:0]  s_len = '0;
  logic        s_wr_ready, s_tx, s_busy, s_done;
  logic [4:0]  s_fill;

  int checks = 0, failures = 0;
  int done_cnt = 0, s_done_cnt = 0;
  logic [7:0] exp_q[$];
  bit mon_abort = 0;
  bit mon_busy = 0;

  always #5 clk = ~clk;

  uart_tx_burst #(
    .C_CLKFREQ(100_000_000), .C_BAUDRATE(10_000_000), .C_STOPBIT(2),
    .C_DATA_BITS(8), .C_DEPTH(1024), .C_LEN_WIDTH(11)
  ) dut (
    .aclk(clk), .areset(areset), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_data_i(wr_data), .wr_clr_i(wr_clr), .data_length_i(len),
    .sent_trig_i(trig),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .tx_o(tx), .busy_o(busy), .done_o(done), .fill_o(fill)
  );

  uart_tx_burst #(
    .C_CLKFREQ(100_000_000), .C_BAUDRATE(25_000_000), .C_STOPBIT(1),
    .C_DATA_BITS(8), .C_DEPTH(16), .C_LEN_WIDTH(5)
  ) s_dut (
    .aclk(clk), .areset(areset), .wr_valid_i(s_wr_valid), .wr_ready_o(s_wr_ready),
    .wr_data_i(s_wr_data), .wr_clr_i(1'b0), .data_length_i(s_len),
    .sent_trig_i(s_trig),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .tx_o(s_tx), .busy_o(s_busy), .done_o(s_done), .fill_o(s_fill)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Pulse counters for the done outputs.
  always @(negedge clk) begin
    if (done)   done_cnt++;
    if (s_done) s_done_cnt++;
  end

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (areset) mon_abort = 1;
    end
  endtask

  // Line monitor: decode each frame at mid-bit and compare with the queue.
  initial begin
    logic       st;
    logic [7:0] d;
    logic [1:0] sp;
    logic       pb;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!areset && tx === 1'b0) begin
        mon_busy = 1; mon_abort = 0; pb = 1'b0;
        mon_wait(4); st = tx;
        for (int i = 0; i < 8; i++) begin mon_wait(10); d[i] = tx; end
`ifdef UART_TX_PARITY_EN
        mon_wait(10); pb = tx;
`endif
        mon_wait(10); sp[0] = tx;
        mon_wait(10); sp[1] = tx;
        if (!mon_abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {23'd0, st, d}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
            check("frame", {20'd0, st, pb, sp, d}, {20'd0, 1'b0, (^e) ^ parity_odd, 2'b11, e});
`else
            check("frame", {20'd0, st, pb, sp, d}, {20'd0, 1'b0, 1'b0, 2'b11, e});
`endif
          end
        end
        mon_busy = 0;
      end
    end
  end

  task automatic wait_done(input int budget, input int base, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin @(negedge clk); n++; end
    check(name, done_cnt - base, 1);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fill", fill, 0);
    check("rst_ready", wr_ready, 1);

    // Two words, burst of two with cycle-exact line timing.
    wr_valid = 1; wr_data = 8'h55; @(negedge clk);
    wr_data = 8'hA3; @(negedge clk);
    wr_valid = 0;
    check("fill_two", fill, 2);
    exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
    base = done_cnt;
    trig = 1; len = 11'd2;
    for (int rel = 1; rel <= 2 * FR + 5; rel++) begin
      @(negedge clk);
      if (rel == 1) begin trig = 0; check("load_busy", busy, 1); check("load_tx", tx, 1); end
      if (rel == 2) check("start_tx", tx, 0);
      if (rel == 50) begin
        check("busy_ready", wr_ready, 0);
        trig = 1; len = 11'd1; wr_valid = 1; wr_data = 8'hFF;
      end
      if (rel == 51) begin trig = 0; wr_valid = 0; end
      if (rel == 60) check("busy_fill", fill, 2);
      if (rel == FR + 1) check("last_stop_tx", tx, 1);
      if (rel == FR + 2) begin check("load2_tx", tx, 1); check("load2_busy", busy, 1); end
      if (rel == FR + 3) check("start2_tx", tx, 0);
      if (rel == 2 * FR + 2) check("done_early", done, 0);
      if (rel == 2 * FR + 3) check("done_at", done, 1);
      if (rel == 2 * FR + 4) begin check("done_after", done, 0); check("idle_busy", busy, 0); end
    end
    check("single_done", done_cnt - base, 1);
    check("fill_kept", fill, 2);

    // Replay of the first word.
    exp_q.push_back(8'h55);
    base = done_cnt;
    trig = 1; len = 11'd1; @(negedge clk); trig = 0;
    wait_done(300, base, "replay_done");

    // Zero-length trigger is ignored.
    base = done_cnt;
    trig = 1; len = 11'd0; @(negedge clk); trig = 0;
    check("len0_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("len0_tx", tx, 1);
    check("len0_done", done_cnt - base, 0);

    // Fill to depth, overflow attempt, clear, clear-vs-write priority.
    wr_clr = 1; @(negedge clk); wr_clr = 0;
    check("clr_fill", fill, 0);
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1; wr_data = i[7:0]; @(negedge clk);
    end
    wr_valid = 0;
    check("full_fill", fill, 1024);
    check("full_ready", wr_ready, 0);
    wr_valid = 1; @(negedge clk); wr_valid = 0;
    check("full_noinc", fill, 1024);
    wr_clr = 1; @(negedge clk); wr_clr = 0;
    check("clr2_fill", fill, 0);
    check("clr2_ready", wr_ready, 1);
    wr_clr = 1; wr_valid = 1; @(negedge clk); wr_clr = 0; wr_valid = 0;
    check("clr_prio", fill, 0);

    // Clamp on the small instance: length 31 with 16 stored words.
    for (int i = 0; i < 16; i++) begin
      s_wr_valid = 1; s_wr_data = i[7:0]; @(negedge clk);
    end
    s_wr_valid = 0;
    check("s_fill", s_fill, 16);
    base = s_done_cnt;
    s_trig = 1; s_len = 5'd31; @(negedge clk); s_trig = 0;
    n = 0;
    for (int c = 0; c < 2000 && s_done_cnt == base; c++) begin
      if (s_busy) n++;
      @(negedge clk);
    end
    check("clamp_busy_cycles", n, 16 * (SFR + 1));
    check("clamp_done", s_done_cnt - base, 1);

    // Reset in the data bits of frame 1.
    wr_valid = 1; wr_data = 8'h3C; @(negedge clk); wr_valid = 0;
    base = done_cnt;
    trig = 1; len = 11'd1;
    for (int rel = 1; rel <= 31; rel++) begin
      @(negedge clk);
      if (rel == 1) trig = 0;
      if (rel == 30) areset = 1;
    end
    areset = 0;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_fill", fill, 0);
    repeat (150) @(negedge clk);
    check("abort_nodone", done_cnt - base, 0);
    trig = 1; len = 11'd0; @(negedge clk); trig = 0;
    check("abort_len0_busy", busy, 0);
    // Storage survives reset: word 0 is still 0x3C.
    exp_q.push_back(8'h3C);
    base = done_cnt;
    trig = 1; len = 11'd1; @(negedge clk); trig = 0;
    wait_done(300, base, "post_reset_done");

    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 500) begin @(negedge clk); n++; end
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
